// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding a small in-order fetch queue.
//
// Holds the fetch PC and drives it straight onto imem_addr. The combinational
// instruction memory returns imem_instr in the same cycle. Each accepted fetch
// stores {pc, instr} in a DEPTH-entry circular queue. Decode drains the queue
// through a valid/ready handshake. A redirect from execute flushes the queue
// and reloads the PC. The redirect has priority over both push and pop.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   DEPTH     queue entries (power of two, >= 2)
//
// Ports:
//   clk             sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   imem_addr       fetch address (equals pc, no register)
//   imem_instr      instruction returned for imem_addr
//   out_valid       queue head holds a valid entry
//   out_ready       decode accepts the head this cycle
//   out_pc          PC of the head entry (0 when empty)
//   out_instr       instruction of the head entry (NOP when empty)
//   out_misaligned  head entry pc[1:0] != 0 (only with FETCH_ALIGN_CHECK_EN)
//   redirect_valid  taken branch/jump: flush and reload the PC
//   redirect_pc     new fetch PC
//
// Optional build macro: FETCH_ALIGN_CHECK_EN adds the out_misaligned output.
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic        out_misaligned,
`endif
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [63:0]   pc;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [63:0]   pc_q    [DEPTH];
   logic [31:0]   instr_q [DEPTH];
   logic          full;
   logic          push;
   logic          pop;

   assign imem_addr = pc;
   assign out_valid = (count != '0);
   assign full      = (count == CW'(DEPTH));
   assign pop       = out_valid & out_ready & ~redirect_valid;
   // A full queue still accepts a fetch when the head leaves in the same cycle.
   assign push      = ~redirect_valid & (~full | pop);

   assign out_pc    = out_valid ? pc_q[rd_ptr]    : 64'h0;
   assign out_instr = out_valid ? instr_q[rd_ptr] : NOP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         pc     <= redirect_pc;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            pc     <= pc + 64'd4;
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_q[i]    <= 64'h0;
            instr_q[i] <= NOP;
         end
      end else if (push) begin
         pc_q[wr_ptr]    <= pc;
         instr_q[wr_ptr] <= imem_instr;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic mis_q [DEPTH];

   assign out_misaligned = out_valid & mis_q[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mis_q[i] <= 1'b0;
         end
      end else if (push) begin
         mis_q[wr_ptr] <= (pc[1:0] != 2'b00);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (RESET_PC=0, DEPTH=2).
// It applies a table of directed vectors and a few hand-written redirect and
// reset sequences. It then runs a randomized phase that is checked against a
// queue-based reference model.
module tb_fetch_unit;

   localparam logic [63:0] RST_PC = 64'h0;
   localparam int          DEP    = 2;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        out_misaligned;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEP)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
`ifdef FETCH_ALIGN_CHECK_EN
      .out_misaligned (out_misaligned),
`endif
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: three loaded words, then an address hash.
   function automatic logic [31:0] mem(input logic [63:0] a);
      case (a)
         64'h0:   return 32'h003100B3;
         64'h4:   return 32'h40628233;
         64'h8:   return 32'h009473B3;
         default: return a[31:0] ^ 32'hDEAD_0000;
      endcase
   endfunction

   assign imem_instr = mem(imem_addr);

   // Reference model: the fetch PC and the list of queued {pc, instr} entries.
   typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
   ent_t        q[$];
   logic [63:0] m_pc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc = RST_PC;
   endtask

   task automatic model_update();
      bit pop_m, push_m;
      if (redirect_valid) begin
         q.delete();
         m_pc = redirect_pc;
      end else begin
         pop_m  = (q.size() != 0) && out_ready;
         push_m = (q.size() < DEP) || pop_m;
         if (pop_m) void'(q.pop_front());
         if (push_m) begin
            q.push_back('{pc: m_pc, instr: mem(m_pc)});
            m_pc = m_pc + 64'd4;
         end
      end
   endtask

   task automatic model_check();
      bit v;
      v = (q.size() != 0);
      chk("m_valid", {63'h0, out_valid}, {63'h0, v});
      chk("m_pc",    out_pc, v ? q[0].pc : 64'h0);
      chk("m_instr", {32'h0, out_instr}, {32'h0, (v ? q[0].instr : NOP)});
      chk("m_addr",  imem_addr, m_pc);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("m_mis", {63'h0, out_misaligned}, {63'h0, (v && q[0].pc[1:0] != 2'b00)});
`endif
   endtask

   // Called at the falling edge: apply inputs, let them settle, compare.
   task automatic drive(input logic rv, input logic [63:0] rpc, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_update();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_pc",    out_pc, 64'h0);
      chk("rst_instr", {32'h0, out_instr}, {32'h0, NOP});
      chk("rst_addr",  imem_addr, RST_PC);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        rdy;
      logic        vld;
      logic [63:0] opc;
      logic [31:0] oin;
      logic [63:0] addr;
   } vec_t;

   vec_t tbl[10];

   initial begin
      // Back-pressure for five cycles after the first valid, then drain.
      tbl[0] = '{1'b0, 1'b0, 64'h0, NOP,          64'h0};
      tbl[1] = '{1'b0, 1'b1, 64'h0, 32'h003100B3, 64'h4};
      tbl[2] = '{1'b0, 1'b1, 64'h0, 32'h003100B3, 64'h8};
      tbl[3] = '{1'b0, 1'b1, 64'h0, 32'h003100B3, 64'h8};
      tbl[4] = '{1'b0, 1'b1, 64'h0, 32'h003100B3, 64'h8};
      tbl[5] = '{1'b0, 1'b1, 64'h0, 32'h003100B3, 64'h8};
      tbl[6] = '{1'b1, 1'b1, 64'h0, 32'h003100B3, 64'h8};
      tbl[7] = '{1'b1, 1'b1, 64'h4, 32'h40628233, 64'hC};
      tbl[8] = '{1'b1, 1'b1, 64'h8, 32'h009473B3, 64'h10};
      tbl[9] = '{1'b1, 1'b1, 64'hC, 32'hDEAD000C, 64'h14};

      @(negedge clk);
      do_reset();

      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 64'h0, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i), {63'h0, out_valid}, {63'h0, tbl[i].vld});
         chk($sformatf("tbl%0d_pc", i),    out_pc, tbl[i].opc);
         chk($sformatf("tbl%0d_instr", i), {32'h0, out_instr}, {32'h0, tbl[i].oin});
         chk($sformatf("tbl%0d_addr", i),  imem_addr, tbl[i].addr);
         tick();
      end

      // Redirect while full with a handshake offered in the same cycle.
      do_reset();
      repeat (3) begin drive(1'b0, 64'h0, 1'b0); tick(); end
      drive(1'b1, 64'h20, 1'b1);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("rd_t1_valid", {63'h0, out_valid}, 64'h0);
      chk("rd_t1_addr",  imem_addr, 64'h20);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("rd_t2_valid", {63'h0, out_valid}, 64'h1);
      chk("rd_t2_pc",    out_pc, 64'h20);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("rd_t3_pc",    out_pc, 64'h24);
      tick();

      // Back-to-back redirects: the last one wins.
      drive(1'b1, 64'h100, 1'b1); tick();
      drive(1'b1, 64'h200, 1'b0); tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("rr_addr", imem_addr, 64'h200);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("rr_pc", out_pc, 64'h200);
      tick();

      // Asynchronous reset between edges while streaming at pc=0x10.
      do_reset();
      repeat (4) begin drive(1'b0, 64'h0, 1'b1); tick(); end
      chk("pre_rst_addr", imem_addr, 64'h10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {63'h0, out_valid}, 64'h0);
      chk("arst_instr", {32'h0, out_instr}, {32'h0, NOP});
      chk("arst_addr",  imem_addr, RST_PC);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 64'h0, 1'b1);
      chk("rec0_valid", {63'h0, out_valid}, 64'h0);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("rec1_pc", out_pc, 64'h0);
      chk("rec1_instr", {32'h0, out_instr}, 32'h003100B3);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("rec2_pc", out_pc, 64'h4);
      tick();

      // PC wrap-around at the top of the address space.
      drive(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1); tick();
      repeat (4) begin drive(1'b0, 64'h0, 1'b1); tick(); end
      chk("wrap_addr", imem_addr, 64'h8);

`ifdef FETCH_ALIGN_CHECK_EN
      drive(1'b1, 64'h22, 1'b1); tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("mis_t1_addr", imem_addr, 64'h22);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("mis_t2_pc", out_pc, 64'h22);
      chk("mis_t2_flag", {63'h0, out_misaligned}, 64'h1);
      tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("mis_t3_pc", out_pc, 64'h26);
      chk("mis_t3_flag", {63'h0, out_misaligned}, 64'h1);
      tick();
      drive(1'b1, 64'h40, 1'b1); tick();
      drive(1'b0, 64'h0, 1'b1); tick();
      drive(1'b0, 64'h0, 1'b1);
      chk("mis_al_pc", out_pc, 64'h40);
      chk("mis_al_flag", {63'h0, out_misaligned}, 64'h0);
      tick();
`endif

      // Randomized traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         logic        rv;
         logic [63:0] rpc;
         rv  = ($urandom_range(0, 15) == 0);
         rpc = {32'h0, $urandom} & 64'h0000_0000_FFFF_FFFC;
         if ($urandom_range(0, 7) == 0) rpc = rpc | 64'h2;
         if ($urandom_range(0, 31) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF4;
         drive(rv, rpc, ($urandom_range(0, 3) != 0));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
